// File: rtl/dmem_pkg.sv
// dmem_pkg: Funct3 codes, FSM state type and alignment helper for dmem_responder.
package dmem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;
  function automatic logic is_aligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    return (funct3[1:0] == F3_H[1:0]) ? !addr_lo[0] :
           (funct3[1:0] == F3_W[1:0]) ? (addr_lo == 2'b00) : 1'b1;
  endfunction
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: memory-control bus between the core (master) and data memory (slave).
interface dmem_responder_if;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] Addr;
  logic [31:0] WrData;
  logic [31:0] RdData;
  logic        Ready;
  logic        Busy;
  logic        MemErr;
  modport master (output MemRead, MemWrite, Funct3, Addr, WrData, input RdData, Ready, Busy, MemErr);
  modport slave (input MemRead, MemWrite, Funct3, Addr, WrData, output RdData, Ready, Busy, MemErr);
endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte-lane write mask/data for stores and extraction/extension for loads.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wr_data,
  input  logic [31:0] i_rd_word,
  output logic [3:0]  o_be,
  output logic [31:0] o_wr_word,
  output logic [31:0] o_rd_data
);
  function automatic logic [35:0] store_lanes(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] d);
    logic [3:0] be;
    logic [31:0] w;
    be = (f3[1:0] == F3_B[1:0]) ? 4'b0001 << lo : (f3[1:0] == F3_H[1:0]) ? (lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    w  = (f3[1:0] == F3_B[1:0]) ? {4{d[7:0]}} : (f3[1:0] == F3_H[1:0]) ? {2{d[15:0]}} : d;
    return {be, w};
  endfunction
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] word);
    logic [31:0] s;
    s = word >> {lo, 3'b000};
    return (f3[1:0] == F3_B[1:0]) ? {{24{s[7] & !f3[2]}}, s[7:0]} :
           (f3[1:0] == F3_H[1:0]) ? {{16{s[15] & !f3[2]}}, s[15:0]} : word;
  endfunction
  assign {o_be, o_wr_word} = store_lanes(i_funct3, i_addr_lo, i_wr_data);
  assign o_rd_data = load_extend(i_funct3, i_addr_lo, i_rd_word);
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data memory with byte/half/word access and error reporting.
// Optional DMEM_PERF_CNT_EN adds LoadCount/StoreCount outputs.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 512,
  parameter int LATENCY     = 2
) (
  input logic clk,
  input logic reset,
  dmem_responder_if.slave bus
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [31:0] LoadCount,
  output logic [31:0] StoreCount
`endif
);
  localparam int IW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY > 1 ? LATENCY - 2 : 0);
  dmem_state_t r_state, w_next;
  logic [3:0] r_cnt;
  logic r_rd, r_wr, w_rd, w_wr, w_req, w_err, w_go_resp;
  logic [2:0] r_f3, w_f3;
  logic [IW+1:0] r_addr, w_addr;
  logic [31:0] r_wdata, w_wdata, w_wr_word, w_rd_data, r_rddata;
  logic [3:0] w_be;
  logic r_ready, r_busy, r_err;
  logic [31:0] r_mem [DEPTH_WORDS];
  logic w_unused;
  assign w_unused = ^bus.Addr[31:IW+2];
  // In IDLE the live inputs stand in for the latched copies so LATENCY=1 can commit on the sampling edge.
  assign w_rd    = (r_state == IDLE) ? bus.MemRead  : r_rd;
  assign w_wr    = (r_state == IDLE) ? bus.MemWrite : r_wr;
  assign w_f3    = (r_state == IDLE) ? bus.Funct3   : r_f3;
  assign w_addr  = (r_state == IDLE) ? bus.Addr[IW+1:0] : r_addr;
  assign w_wdata = (r_state == IDLE) ? bus.WrData   : r_wdata;
  assign w_req   = bus.MemRead | bus.MemWrite;
  assign w_err   = (w_rd & w_wr) | !is_aligned(w_f3, w_addr[1:0]) | (w_f3[1:0] == 2'b11) | (w_f3[2] & (w_wr | w_f3[1]));
  assign w_next  = (r_state == IDLE) ? (w_req ? (LATENCY == 1 ? RESP : WAIT) : IDLE) :
                   (r_state == WAIT) ? (r_cnt == 4'd0 ? RESP : WAIT) : IDLE;
  assign w_go_resp = (w_next == RESP);
  dmem_lane_align u_align (
    .i_funct3  (w_f3),
    .i_addr_lo (w_addr[1:0]),
    .i_wr_data (w_wdata),
    .i_rd_word (r_mem[w_addr[IW+1:2]]),
    .o_be      (w_be),
    .o_wr_word (w_wr_word),
    .o_rd_data (w_rd_data)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      r_ready  <= 1'b0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
      r_rddata <= 32'd0;
`ifdef DMEM_PERF_CNT_EN
      LoadCount  <= 32'd0;
      StoreCount <= 32'd0;
`endif
    end else begin
      r_state <= w_next;
      r_ready <= w_go_resp;
      r_err   <= w_go_resp & w_err;
      r_busy  <= (w_next != IDLE);
      r_cnt   <= (r_state == WAIT) ? r_cnt - 4'd1 : CNT_INIT;
      if (r_state == IDLE && w_req) {r_rd, r_wr, r_f3, r_addr, r_wdata} <= {bus.MemRead, bus.MemWrite, bus.Funct3, bus.Addr[IW+1:0], bus.WrData};
      if (w_go_resp && w_rd && !w_err) r_rddata <= w_rd_data;
`ifdef DMEM_PERF_CNT_EN
      if (w_go_resp && w_rd && !w_err) LoadCount <= LoadCount + 32'd1;
      if (w_go_resp && w_wr && !w_err) StoreCount <= StoreCount + 32'd1;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (!reset && w_go_resp && w_wr && !w_err)
      for (int i = 0; i < 4; i++)
        if (w_be[i]) r_mem[w_addr[IW+1:2]][8*i +: 8] <= w_wr_word[8*i +: 8];
  end
  assign bus.RdData = r_rddata;
  assign bus.Ready  = r_ready;
  assign bus.Busy   = r_busy;
  assign bus.MemErr = r_err;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: table-driven directed vectors, corner sequences and randomized model check.
module tb_dmem_responder;
  localparam int LAT = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  dmem_responder_if bus();
`ifdef DMEM_PERF_CNT_EN
  logic [31:0] LoadCount, StoreCount;
`endif
  dmem_responder #(.DEPTH_WORDS(512), .LATENCY(LAT)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef DMEM_PERF_CNT_EN
    ,
    .LoadCount(LoadCount),
    .StoreCount(StoreCount)
`endif
  );
  always #5 clk = ~clk;

  typedef struct {
    logic rd, wr;
    logic [2:0] f3;
    logic [31:0] a, d;
    logic err;
    logic [31:0] q;
  } vec_t;
  vec_t tv[$];
  logic [7:0] m_mem [2048];
  logic [31:0] m_q;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic rd, wr, input logic [2:0] f3, input logic [31:0] a, d, input logic err, input logic [31:0] q);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.a = a; v.d = d; v.err = err; v.q = q;
    tv.push_back(v);
  endtask

  // Called at a negedge in IDLE; returns at a negedge in IDLE after the response.
  task automatic do_req(input logic rd, wr, input logic [2:0] f3, input logic [31:0] a, d,
                        output logic err, output logic [31:0] q, output int lat);
    bus.MemRead = rd; bus.MemWrite = wr; bus.Funct3 = f3; bus.Addr = a; bus.WrData = d;
    lat = 0;
    err = 1'bx;
    q = 'x;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.Ready) begin
        lat = k;
        err = bus.MemErr;
        q = bus.RdData;
        break;
      end
      if (bus.MemErr !== 1'b0) check("memerr_without_ready", {31'd0, bus.MemErr}, 32'd0);
    end
    bus.MemRead = 1'b0; bus.MemWrite = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic m_err(input logic rd, wr, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    sz = 1 << f3[1:0];
    if (rd && wr) return 1'b1;
    if (f3 == 3'd3 || f3 >= 3'd6 || (wr && f3 >= 3'd4)) return 1'b1;
    return (a % sz) != 0;
  endfunction

  // Byte-addressed reference; memory aliases modulo 2048 bytes.
  task automatic m_access(input logic rd, wr, input logic [2:0] f3, input logic [31:0] a, d);
    int sz, base;
    logic [31:0] v;
    sz = 1 << f3[1:0];
    base = int'(a % 2048);
    if (m_err(rd, wr, f3, a)) return;
    if (wr) begin
      for (int i = 0; i < sz; i++) m_mem[base + i] = d[8*i +: 8];
    end else begin
      v = 0;
      for (int i = 0; i < sz; i++) v = v | (32'(m_mem[base + i]) << (8 * i));
      if (!f3[2] && sz == 1 && v[7]) v = v | 32'hFFFF_FF00;
      if (!f3[2] && sz == 2 && v[15]) v = v | 32'hFFFF_0000;
      m_q = v;
    end
  endtask

  initial begin
    logic e;
    logic [31:0] q, a, d;
    logic [2:0] f3;
    logic rd, wr;
    int lat, r;
    bus.MemRead = 1'b0; bus.MemWrite = 1'b0; bus.Funct3 = 3'd0; bus.Addr = 32'd0; bus.WrData = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_ready", {31'd0, bus.Ready}, 32'd0);
    check("reset_busy", {31'd0, bus.Busy}, 32'd0);
    check("reset_memerr", {31'd0, bus.MemErr}, 32'd0);
    check("reset_rddata", bus.RdData, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    add(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 32'h0);
    add(1, 0, 3'b010, 32'h10, 32'h0, 0, 32'hDEADBEEF);
    add(0, 1, 3'b000, 32'h13, 32'h80, 0, 32'hDEADBEEF);
    add(1, 0, 3'b000, 32'h13, 32'h0, 0, 32'hFFFFFF80);
    add(1, 0, 3'b100, 32'h13, 32'h0, 0, 32'h00000080);
    add(1, 0, 3'b010, 32'h10, 32'h0, 0, 32'h80ADBEEF);
    add(0, 1, 3'b001, 32'h11, 32'h1234, 1, 32'h80ADBEEF);
    add(1, 0, 3'b010, 32'h10, 32'h0, 0, 32'h80ADBEEF);
    add(1, 1, 3'b010, 32'h10, 32'h0, 1, 32'h80ADBEEF);
    add(1, 0, 3'b010, 32'h10, 32'h0, 0, 32'h80ADBEEF);
    add(1, 0, 3'b011, 32'h10, 32'h0, 1, 32'h80ADBEEF);
    add(1, 0, 3'b001, 32'h12, 32'h0, 0, 32'hFFFF80AD);
    add(1, 0, 3'b101, 32'h12, 32'h0, 0, 32'h000080AD);
    add(0, 1, 3'b010, 32'h800, 32'hCAFEF00D, 0, 32'h000080AD);
    add(1, 0, 3'b010, 32'h0, 32'h0, 0, 32'hCAFEF00D);
    add(0, 1, 3'b001, 32'h2, 32'h5678_1234, 0, 32'hCAFEF00D);
    add(1, 0, 3'b010, 32'h0, 32'h0, 0, 32'h1234F00D);
    add(0, 1, 3'b100, 32'h0, 32'h0, 1, 32'h1234F00D);
    add(1, 0, 3'b010, 32'h0, 32'h0, 0, 32'h1234F00D);
    add(1, 0, 3'b010, 32'h6, 32'h0, 1, 32'h1234F00D);
    foreach (tv[i]) begin
      do_req(tv[i].rd, tv[i].wr, tv[i].f3, tv[i].a, tv[i].d, e, q, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT));
      check($sformatf("vec%0d_memerr", i), {31'd0, e}, {31'd0, tv[i].err});
      check($sformatf("vec%0d_rddata", i), q, tv[i].q);
    end

    // Request held high through RESP is sampled again in the following IDLE cycle.
    bus.MemRead = 1'b1; bus.MemWrite = 1'b0; bus.Funct3 = 3'b010; bus.Addr = 32'h0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.Ready) begin lat = k; break; end
    end
    check("b2b_first_latency", 32'(lat), 32'(LAT));
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.Ready) begin lat = k; break; end
    end
    check("b2b_second_gap", 32'(lat), 32'(LAT + 1));
    check("b2b_rddata", bus.RdData, 32'h1234F00D);
    bus.MemRead = 1'b0;
    @(negedge clk);

    // Store aborted by reset one cycle before RESP.
    bus.MemWrite = 1'b1; bus.Funct3 = 3'b010; bus.Addr = 32'h10; bus.WrData = 32'h11111111;
    @(negedge clk);
    check("abort_busy_before_reset", {31'd0, bus.Busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_no_ready", {31'd0, bus.Ready}, 32'd0);
    check("abort_busy_cleared", {31'd0, bus.Busy}, 32'd0);
    check("abort_rddata_cleared", bus.RdData, 32'd0);
`ifdef DMEM_PERF_CNT_EN
    check("abort_storecount", StoreCount, 32'd0);
    check("abort_loadcount", LoadCount, 32'd0);
`endif
    bus.MemWrite = 1'b0;
    @(negedge clk);
    check("abort_no_ready_late", {31'd0, bus.Ready}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    do_req(1, 0, 3'b010, 32'h10, 32'h0, e, q, lat);
    check("abort_mem_unchanged", q, 32'h80ADBEEF);
    check("abort_reload_latency", 32'(lat), 32'(LAT));

    // Randomized traffic over 8 aliased words against the byte-level model.
    for (int w = 0; w < 8; w++) begin
      d = $urandom;
      a = 32'(w * 4);
      m_access(0, 1, 3'b010, a, d);
      do_req(0, 1, 3'b010, a, d, e, q, lat);
      check($sformatf("init%0d_memerr", w), {31'd0, e}, 32'd0);
    end
    m_q = q;
    for (int n = 0; n < 80; n++) begin
      a = ($urandom & 32'hFFFF_F800) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      f3 = 3'($urandom_range(0, 7));
      d = $urandom;
      r = $urandom_range(0, 9);
      rd = (r == 0) || (r < 5);
      wr = (r == 0) || (r >= 5);
      m_access(rd, wr, f3, a, d);
      do_req(rd, wr, f3, a, d, e, q, lat);
      check($sformatf("rnd%0d_latency", n), 32'(lat), 32'(LAT));
      check($sformatf("rnd%0d_memerr", n), {31'd0, e}, {31'd0, m_err(rd, wr, f3, a)});
      check($sformatf("rnd%0d_rddata", n), q, m_q);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
